// File: rtl/ntsc_pixel_packer.sv
// Packs decoded NTSC pixels into memory words and buffers them for a memory writer.
//
// Ports:
//   clock, reset      rising-edge clock; synchronous active-high reset
//   frame_start       pulse: decoder starts a new frame
//   line_start        pulse: decoder starts a new line
//   pixel_in_valid    pulse: pixel_in carries a pixel
//   pixel_in          decoded pixel value
//   done_ntsc         memory side has written the head word; pops the buffer
//   captured_pixels   head word of the buffer (zero while empty)
//   pixel_flag        buffer non-empty, captured_pixels valid
//   frame_flag        pulse: every word of the frame has left the buffer
//   overflow          sticky: a completed word was dropped on a full buffer
module ntsc_pixel_packer #(
  parameter int unsigned PIX_W         = 8,
  parameter int unsigned PIX_PER_WORD  = 4,
  parameter int unsigned IMAGE_WIDTH   = 640,
  parameter int unsigned IMAGE_HEIGHT  = 480,
  parameter int unsigned FIFO_DEPTH    = 4,
  localparam int unsigned WORD_W       = PIX_W * PIX_PER_WORD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pixel_in_valid,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              done_ntsc,
  output logic [WORD_W-1:0] captured_pixels,
  output logic              pixel_flag,
  output logic              frame_flag,
  output logic              overflow
);

  localparam int unsigned X_W    = $clog2(IMAGE_WIDTH + 1);
  localparam int unsigned Y_W    = $clog2(IMAGE_HEIGHT + 1);
  localparam int unsigned SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [X_W-1:0]    XEnd     = X_W'(IMAGE_WIDTH);
  localparam logic [X_W-1:0]    XLast    = X_W'(IMAGE_WIDTH - 1);
  localparam logic [Y_W-1:0]    YEnd     = Y_W'(IMAGE_HEIGHT);
  localparam logic [Y_W-1:0]    YLast    = Y_W'(IMAGE_HEIGHT - 1);
  localparam logic [SLOT_W-1:0] SlotLast = SLOT_W'(PIX_PER_WORD - 1);
  localparam logic [PTR_W-1:0]  PtrLast  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CntFull  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

  state_e             state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [WORD_W-1:0]  pack_q, pack_d, pack_wr;
  logic               pending_q, pending_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [WORD_W-1:0]  mem_q [FIFO_DEPTH];
  logic               push, pop, push_ok, empty, full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Pack register with the current pixel dropped into its slot; first pixel lands in the MS bits.
  always_comb begin
    pack_wr = pack_q;
    for (int s = 0; s < PIX_PER_WORD; s++) begin
      if (slot_q == SLOT_W'(s)) pack_wr[WORD_W-1-s*PIX_W -: PIX_W] = pixel_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    slot_d     = slot_q;
    pack_d     = pack_q;
    pending_d  = pending_q;
    push       = 1'b0;
    frame_flag = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StCapture;
          x_d     = '0;
          y_d     = '0;
          slot_d  = '0;
          pack_d  = '0;
        end
      end
      StCapture: begin
        if (frame_start) begin
          pending_d = 1'b1;
          state_d   = StDrain;
          slot_d    = '0;
          pack_d    = '0;
        end else if (line_start) begin
          slot_d = '0;
          pack_d = '0;
          x_d    = '0;
          // Empty lines (repeated line_start) do not consume a row.
          if (x_q != '0 && y_q != YEnd) y_d = y_q + 1'b1;
        end else if (pixel_in_valid && x_q < XEnd && y_q < YEnd) begin
          pack_d = pack_wr;
          x_d    = x_q + 1'b1;
          if (slot_q == SlotLast) begin
            push   = 1'b1;
            slot_d = '0;
            if (y_q == YLast && x_q == XLast) state_d = StDrain;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (frame_start) pending_d = 1'b1;
        if (empty) begin
          frame_flag = 1'b1;
          pending_d  = 1'b0;
          if (pending_q || frame_start) begin
            state_d = StCapture;
            x_d     = '0;
            y_d     = '0;
            slot_d  = '0;
            pack_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Word buffer: a simultaneous pop frees the slot a push into a full buffer needs.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CntFull);
    pop        = done_ntsc & ~empty;
    push_ok    = push & (~full | pop);
    wr_ptr_d   = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    overflow_d = overflow_q | (push & full & ~pop);
    count_d    = count_q;
    if (push_ok && !pop) count_d = count_q + 1'b1;
    if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      slot_q     <= '0;
      pack_q     <= '0;
      pending_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      slot_q     <= slot_d;
      pack_q     <= pack_d;
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the output is gated to zero while empty.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= pack_wr;
  end

  assign captured_pixels = empty ? '0 : mem_q[rd_ptr_q];
  assign pixel_flag      = ~empty;
  assign overflow        = overflow_q;

endmodule
